hermes_switch_ctrl: RTL and testbench

- Central switch controller for a 5-port Hermes router.
- Arbitrates round-robin among input buffers that present a header flit.
- Computes the XY output port from the header target address and checks that output is free.
- Establishes and tears down input→output crossbar connections; publishes the connection tables that steer the crossbar muxes.

---
 rtl/hermes_switch_ctrl.sv | 131 +++++++++++++
 tb/tb_hermes_switch_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hermes_switch_ctrl.sv
// Hermes 5-port switch controller: round-robin header arbitration, XY routing,
// and the input/output connection tables that steer the crossbar muxes.
module hermes_switch_ctrl #(
   parameter int         NPORT = 5,
   parameter logic [7:0] ADDR  = 8'h11
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [NPORT-1:0] h,
   input  logic [15:0]      header_in [NPORT],
   input  logic [NPORT-1:0] pkt_end,
   output logic [NPORT-1:0] ack_h,
   output logic [NPORT-1:0] in_busy,
   output logic [NPORT-1:0] out_busy,
   output logic [2:0]       mux_in  [NPORT],
   output logic [2:0]       mux_out [NPORT]
);

   localparam logic [2:0] EAST  = 3'd0;
   localparam logic [2:0] WEST  = 3'd1;
   localparam logic [2:0] NORTH = 3'd2;
   localparam logic [2:0] SOUTH = 3'd3;
   localparam logic [2:0] LOCAL = 3'd4;

   typedef enum logic [1:0] {S_IDLE, S_ARB, S_ROUTE, S_GRANT} state_t;

   state_t           state_q, state_d;
   logic [2:0]       ptr_q, sel_q, dest_q;
   logic [2:0]       arb_sel, cand, route_dest;
   logic             arb_found;
   logic [3:0]       tx, ty;
   logic [NPORT-1:0] req, in_busy_d, out_busy_d;
   logic             hdr_unused;

   assign req = h & ~in_busy;

   // Round-robin search starting just after the previous winner.
   always_comb begin
      arb_found = 1'b0;
      arb_sel   = ptr_q;
      cand      = ptr_q;
      for (int k = 1; k <= NPORT; k++) begin
         cand = 3'((int'(ptr_q) + k) % NPORT);
         if (!arb_found && req[cand]) begin
            arb_found = 1'b1;
            arb_sel   = cand;
         end
      end
   end

   always_comb begin
      tx = header_in[sel_q][7:4];
      ty = header_in[sel_q][3:0];
      if (tx > ADDR[7:4])      route_dest = EAST;
      else if (tx < ADDR[7:4]) route_dest = WEST;
      else if (ty > ADDR[3:0]) route_dest = NORTH;
      else if (ty < ADDR[3:0]) route_dest = SOUTH;
      else                     route_dest = LOCAL;
   end

   // Only the low header byte carries the XY target.
   always_comb begin
      hdr_unused = 1'b0;
      for (int i = 0; i < NPORT; i++) hdr_unused = hdr_unused ^ (^header_in[i][15:8]);
   end

   // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
   always_comb begin
      state_d = state_q;
      ack_h   = '0;
      case (state_q)
         S_IDLE:  if (req != '0) state_d = S_ARB;
         S_ARB:   state_d = arb_found ? S_ROUTE : S_IDLE;
         S_ROUTE: state_d = (h[sel_q] && !out_busy[route_dest]) ? S_GRANT : S_IDLE;
         S_GRANT: begin
            ack_h[sel_q] = 1'b1;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A grant never hits a released pair: the granted input and output were both free.
   always_comb begin
      in_busy_d  = in_busy;
      out_busy_d = out_busy;
      for (int i = 0; i < NPORT; i++) begin
         if (pkt_end[i] && in_busy[i]) begin
            in_busy_d[i]          = 1'b0;
            out_busy_d[mux_in[i]] = 1'b0;
         end
      end
      if (state_q == S_GRANT) begin
         in_busy_d[sel_q]   = 1'b1;
         out_busy_d[dest_q] = 1'b1;
      end
   end

   // NOTE: clocked state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         ptr_q    <= LOCAL;
         sel_q    <= '0;
         dest_q   <= '0;
         in_busy  <= '0;
         out_busy <= '0;
         // NOTE: the connection tables are port-visible, so they are cleared on reset like any register.
         mux_in   <= '{default: '0};
         mux_out  <= '{default: '0};
      end else begin
         state_q  <= state_d;
         in_busy  <= in_busy_d;
         out_busy <= out_busy_d;
         if (state_q == S_ARB && arb_found) begin
            ptr_q <= arb_sel;
            sel_q <= arb_sel;
         end
         if (state_q == S_ROUTE) dest_q <= route_dest;
         if (state_q == S_GRANT) begin
            mux_in[sel_q]   <= dest_q;
            mux_out[dest_q] <= sel_q;
         end
      end
   end

   a_ack_onehot: assert property (@(posedge clock) disable iff (reset) $onehot0(ack_h));
   a_busy_balance: assert property (@(posedge clock) disable iff (reset)
      $countones(in_busy) == $countones(out_busy));

endmodule

// File: tb/tb_hermes_switch_ctrl.sv
// Self-checking bench for hermes_switch_ctrl: routing vector table plus hand-written
// multi-cycle sequences, with an ack scoreboard checked by a negedge monitor.
module tb_hermes_switch_ctrl;

   localparam logic [2:0] EAST  = 3'd0;
   localparam logic [2:0] WEST  = 3'd1;
   localparam logic [2:0] NORTH = 3'd2;
   localparam logic [2:0] SOUTH = 3'd3;
   localparam logic [2:0] LOCAL = 3'd4;

   typedef struct {
      logic [2:0]  port;
      logic [15:0] hdr;
      logic [2:0]  dest;
   } vec_t;

   typedef struct {
      logic [2:0] port;
      int         cyc;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  h = '0;
   logic [15:0] header_in [5];
   logic [4:0]  pkt_end = '0;
   logic [4:0]  ack_h, in_busy, out_busy;
   logic [2:0]  mux_in  [5];
   logic [2:0]  mux_out [5];

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   bit   mon_en = 1'b0;
   exp_t sb[$];
   vec_t vecs[10];

   hermes_switch_ctrl #(.NPORT(5), .ADDR(8'h11)) dut (
      .clock(clock), .reset(reset), .h(h), .header_in(header_in), .pkt_end(pkt_end),
      .ack_h(ack_h), .in_busy(in_busy), .out_busy(out_busy),
      .mux_in(mux_in), .mux_out(mux_out)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clock);
   endtask

   task automatic sb_push(input logic [2:0] p, input int delay);
      sb.push_back('{port: p, cyc: cyc + delay});
   endtask

   task automatic check_zero(input string tag);
      logic [14:0] mi, mo;
      for (int i = 0; i < 5; i++) begin
         mi[3*i +: 3] = mux_in[i];
         mo[3*i +: 3] = mux_out[i];
      end
      check({tag, "_ack_h"}, int'(ack_h), 0);
      check({tag, "_in_busy"}, int'(in_busy), 0);
      check({tag, "_out_busy"}, int'(out_busy), 0);
      check({tag, "_mux_in"}, int'(mi), 0);
      check({tag, "_mux_out"}, int'(mo), 0);
   endtask

   // Scoreboard and invariant monitor.
   always @(negedge clock) begin : mon
      exp_t e;
      if (mon_en) begin
         if (ack_h != '0) begin
            if (sb.size() == 0) begin
               check("unexpected_ack", int'(ack_h), 0);
            end else begin
               e = sb.pop_front();
               check("ack_port", int'(ack_h), 1 << e.port);
               check("ack_cycle", cyc, e.cyc);
            end
         end
         check("inv_ack_onehot", int'($onehot0(ack_h)), 1);
         check("inv_busy_count", $countones(in_busy), $countones(out_busy));
         for (int i = 0; i < 5; i++)
            if (in_busy[i]) check("inv_mux_pair", int'(mux_out[mux_in[i]]), i);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{3'd2, 16'h0011, LOCAL};
      vecs[1] = '{3'd4, 16'h0021, EAST};
      vecs[2] = '{3'd0, 16'h0001, WEST};
      vecs[3] = '{3'd1, 16'h0010, SOUTH};
      vecs[4] = '{3'd3, 16'h0012, NORTH};
      vecs[5] = '{3'd0, 16'h0055, EAST};
      vecs[6] = '{3'd1, 16'h0015, NORTH};
      vecs[7] = '{3'd4, 16'hAB13, NORTH};
      vecs[8] = '{3'd0, 16'h0021, EAST};
      vecs[9] = '{3'd2, 16'h0110, SOUTH};
      for (int i = 0; i < 5; i++) header_in[i] = '0;

      repeat (2) tick();
      reset = 1'b0;
      at_neg();
      mon_en = 1'b1;
      check_zero("reset");

      // Round-robin from ptr=LOCAL: SOUTH wins first, LOCAL follows.
      tick();
      header_in[3] = 16'h0012;
      header_in[4] = 16'h0021;
      h = 5'b11000;
      sb_push(3'd3, 3);
      sb_push(3'd4, 7);
      repeat (3) tick();
      h[3] = 1'b0;
      repeat (4) tick();
      h[4] = 1'b0;
      tick(); at_neg();
      check("rr_out_busy", int'(out_busy), 5'b00101);
      check("rr_in_busy", int'(in_busy), 5'b11000);
      check("rr_mux_in3", int'(mux_in[3]), int'(NORTH));
      check("rr_mux_in4", int'(mux_in[4]), int'(EAST));
      check("rr_mux_out2", int'(mux_out[2]), 3);
      check("rr_mux_out0", int'(mux_out[0]), 4);
      pkt_end = 5'b11000;
      tick();
      pkt_end = '0;
      at_neg();
      check("rr_dual_release", int'({in_busy, out_busy}), 0);

      // Output contention on EAST: LOCAL is blocked until WEST releases.
      tick();
      header_in[1] = 16'h0021;
      header_in[4] = 16'h0021;
      h = 5'b10010;
      sb_push(3'd1, 3);
      sb_push(3'd4, 13);
      repeat (3) tick();
      h[1] = 1'b0;
      repeat (4) tick(); at_neg();
      check("cont_blocked_ack", int'(ack_h), 0);
      check("cont_blocked_out_busy", int'(out_busy), 5'b00001);
      repeat (3) tick();
      pkt_end[1] = 1'b1;
      tick();
      pkt_end = '0;
      at_neg();
      check("cont_release_out", int'(out_busy), 0);
      check("cont_release_in", int'(in_busy), 0);
      repeat (2) tick();
      h[4] = 1'b0;
      tick(); at_neg();
      check("cont_mux_out0", int'(mux_out[0]), 4);
      check("cont_mux_in4", int'(mux_in[4]), int'(EAST));
      check("cont_out_busy", int'(out_busy), 5'b00001);
      check("cont_in_busy", int'(in_busy), 5'b10000);
      pkt_end[4] = 1'b1;
      tick();
      pkt_end = '0;
      at_neg();
      check("cont_final_release", int'({in_busy, out_busy}), 0);

      // Routing table: one requester at a time, connect then release.
      for (int v = 0; v < 10; v++) begin
         tick();
         header_in[vecs[v].port] = vecs[v].hdr;
         h[vecs[v].port] = 1'b1;
         sb_push(vecs[v].port, 3);
         repeat (3) tick();
         h = '0;
         tick(); at_neg();
         check("vec_mux_in", int'(mux_in[vecs[v].port]), int'(vecs[v].dest));
         check("vec_mux_out", int'(mux_out[vecs[v].dest]), int'(vecs[v].port));
         check("vec_out_busy", int'(out_busy), 1 << vecs[v].dest);
         check("vec_in_busy", int'(in_busy), 1 << vecs[v].port);
         pkt_end[vecs[v].port] = 1'b1;
         tick();
         pkt_end = '0;
         at_neg();
         check("vec_release", int'({in_busy, out_busy}), 0);
      end

      // Reset while in S_ROUTE: no ack, everything cleared, re-request served.
      tick();
      header_in[4] = 16'h0021;
      h[4] = 1'b1;
      repeat (2) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sb_push(3'd4, 3);
      at_neg();
      check_zero("midreset");
      repeat (3) tick();
      h = '0;
      tick(); at_neg();
      check("midreset_mux_out0", int'(mux_out[0]), 4);
      check("midreset_out_busy", int'(out_busy), 5'b00001);
      pkt_end[4] = 1'b1;
      tick();
      pkt_end = '0;
      at_neg();
      check("midreset_release", int'({in_busy, out_busy}), 0);

      // Header withdrawn in S_ARB (d=1) or S_ROUTE (d=2); FSM must be idle by cycle 3.
      for (int d = 1; d <= 2; d++) begin
         tick();
         header_in[4] = 16'h0021;
         h[4] = 1'b1;
         repeat (d) tick();
         h[4] = 1'b0;
         repeat (3 - d) tick();
         header_in[0] = 16'h0001;
         h[0] = 1'b1;
         sb_push(3'd0, 3);
         repeat (3) tick();
         h = '0;
         tick(); at_neg();
         check("abort_in_busy", int'(in_busy), 5'b00001);
         check("abort_out_busy", int'(out_busy), 1 << WEST);
         pkt_end[2] = 1'b1;
         tick();
         pkt_end = '0;
         at_neg();
         check("ignore_pkt_end_in", int'(in_busy), 5'b00001);
         check("ignore_pkt_end_out", int'(out_busy), 1 << WEST);
         pkt_end[0] = 1'b1;
         tick();
         pkt_end = '0;
         at_neg();
         check("abort_release", int'({in_busy, out_busy}), 0);
      end

      repeat (4) tick();
      at_neg();
      check("sb_drain", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
